ex_div: RTL and testbench
=========================

// Module: ex_div
// PURPOSE
//  Multi-cycle RV32M divider (DIV/DIVU/REM/REMU) inside the execute stage, directly
//  downstream of the ID/EX pipeline register. Takes operands and rd from the ID/EX outputs.
//  Requests a pipeline hold from ctrl while it iterates, so ID/EX keeps the instruction stable.
//  Returns one result with the rd write enable when finished.
// PARAMETERS
//  XLEN     32   operand/result width in bits
//  CNT_W    5    iteration counter width; must equal log2(XLEN)
// PORTS
//  clk         in   1       clock
//  rstn        in   1       asynchronous active-low reset
//  start_i     in   1       ex has decoded a DIV/DIVU/REM/REMU from ID/EX this cycle
//  op_i        in   2       funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//  dividend_i  in   XLEN    rs1 value (op1 from ID/EX)
//  divisor_i   in   XLEN    rs2 value (op2 from ID/EX)
//  rd_addr_i   in   5       destination register
//  flush_i     in   1       ctrl flush of the ex stage (jump/trap); aborts the operation
//  hold_req_o  out  1       to ctrl: stall IF/ID/ID-EX (combinational)
//  busy_o      out  1       divider is not IDLE
//  valid_o     out  1       result_o/rd_addr_o/regs_wen_o valid for exactly this cycle
//  result_o    out  XLEN    quotient or remainder
//  rd_addr_o   out  5       latched rd_addr_i
//  regs_wen_o  out  1       equals valid_o
// BEHAVIOUR
//  Reset: state IDLE, counter 0, all outputs 0, including result_o and rd_addr_o.
//  States: IDLE -> CALC -> DONE -> IDLE. Special cases go IDLE -> DONE.
//  IDLE with start_i=1 and flush_i=0:
//   - latch op_i and rd_addr_i
//   - signed ops (DIV/REM): latch |dividend|, |divisor| and both sign bits;
//     unsigned ops latch the operands raw
//   - divisor==0, or a signed op with dividend==0x80000000 and divisor==-1: precompute
//     the special result and go to DONE
//   - otherwise clear counter, partial remainder and quotient; go to CALC
//  CALC (restoring, one quotient bit per cycle, MSB first):
//   - shift {rem,quo} left by 1
//   - if rem >= divisor, subtract divisor and set quo[0]
//   - the compare/subtract is XLEN+1 bits wide
//   - counter increments; go to DONE after the iteration where counter==XLEN-1
//  DONE:
//   - valid_o=1 and regs_wen_o=1 for one cycle, then IDLE
//   - start_i is ignored in DONE (the same instruction is still in EX)
//  Sign fix-up applied when the result is registered into DONE:
//   - quotient is negated if signed and the operand signs differ
//   - remainder takes the sign of the dividend
//  Special results:
//   - divide by zero: quotient = all ones; remainder = dividend
//   - signed overflow: quotient = 0x80000000; remainder = 0
//  Latency:
//   - normal: start seen in cycle T, valid_o in cycle T+XLEN+1 (T+33)
//   - special: valid_o in cycle T+1
//  hold_req_o = (IDLE & start_i & !flush_i) | CALC. It is low in DONE, so the pipeline
//  advances on the DONE edge and ID/EX loads the next instruction.
//  busy_o = (state != IDLE).
//  flush_i:
//   - synchronous; in any state, next state IDLE with valid_o=0
//   - has priority over start_i
//   - no regs_wen_o is ever produced for a flushed operation
//  result_o/rd_addr_o hold their last value outside valid_o; consumers must gate on valid_o.
//  rstn asserted mid-operation: immediate return to the reset values, no result produced.
// TESTING
//  DIVU 100/7 -> hold_req_o high for 33 cycles; valid_o at T+33 with 14; REMU -> 2, regs_wen_o=1.
//  DIV 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIV 7/0xFFFFFFFE -> 0xFFFFFFFD.
//  DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, both with valid_o at T+1 and no CALC cycles.
//  DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, valid at T+1.
//  flush_i at CALC cycle 10 -> busy_o=0 and hold_req_o=0 next cycle, no valid_o; DIVU 9/3 then -> 3.
//  rstn low mid-CALC -> all outputs 0 asynchronously; after release start_i DIVU 8/2 -> 4 at T+33.

Source files
------------

// File: rtl/ex_div.sv
// Multi-cycle RV32M restoring divider: one quotient bit per cycle, result in T+XLEN+1 (T+1 for div-by-zero/overflow).
// Holds the pipeline via hold_req_o while accepting or iterating; flush aborts silently in any state.
module ex_div #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            start_i,
   input  logic [1:0]      op_i,
   input  logic [XLEN-1:0] dividend_i,
   input  logic [XLEN-1:0] divisor_i,
   input  logic [4:0]      rd_addr_i,
   input  logic            flush_i,
   output logic            hold_req_o,
   output logic            busy_o,
   output logic            valid_o,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      rd_addr_o,
   output logic            regs_wen_o
);
   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

   localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN-1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             is_rem_q, is_rem_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic [4:0]       rd_q, rd_d;
   logic [XLEN-1:0]  quo_q, quo_d;
   logic [XLEN-1:0]  rem_q, rem_d;
   logic [XLEN-1:0]  dvs_q, dvs_d;
   logic [XLEN-1:0]  res_q, res_d;

   logic            signed_in, a_neg, b_neg, div_zero, ovf;
   logic [XLEN-1:0] a_abs, b_abs;
   logic [XLEN:0]   rem_sh, diff;
   logic [XLEN-1:0] quo_nx, rem_nx, quo_fix, rem_fix;

   assign signed_in = ~op_i[0];
   assign a_neg     = signed_in & dividend_i[XLEN-1];
   assign b_neg     = signed_in & divisor_i[XLEN-1];
   assign a_abs     = a_neg ? -dividend_i : dividend_i;
   assign b_abs     = b_neg ? -divisor_i  : divisor_i;
   assign div_zero  = (divisor_i == '0);
   assign ovf       = signed_in && (dividend_i == MIN_NEG) && (divisor_i == '1);

   // One restoring step; a borrow out of the XLEN+1-bit subtract means rem < divisor.
   assign rem_sh  = {rem_q, quo_q[XLEN-1]};
   assign diff    = rem_sh - {1'b0, dvs_q};
   assign quo_nx  = {quo_q[XLEN-2:0], ~diff[XLEN]};
   assign rem_nx  = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
   assign quo_fix = qneg_q ? -quo_nx : quo_nx;
   assign rem_fix = rneg_q ? -rem_nx : rem_nx;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      is_rem_d = is_rem_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      rd_d     = rd_q;
      quo_d    = quo_q;
      rem_d    = rem_q;
      dvs_d    = dvs_q;
      res_d    = res_q;
      case (state_q)
         IDLE: begin
            if (start_i && !flush_i) begin
               is_rem_d = op_i[1];
               qneg_d   = a_neg ^ b_neg;
               rneg_d   = a_neg;
               rd_d     = rd_addr_i;
               quo_d    = a_abs;
               dvs_d    = b_abs;
               rem_d    = '0;
               cnt_d    = '0;
               if (div_zero) begin
                  res_d   = op_i[1] ? dividend_i : '1;
                  state_d = DONE;
               end else if (ovf) begin
                  res_d   = op_i[1] ? '0 : MIN_NEG;
                  state_d = DONE;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            quo_d = quo_nx;
            rem_d = rem_nx;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               res_d   = is_rem_q ? rem_fix : quo_fix;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush_i) begin
         state_d = IDLE;
         res_d   = res_q;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         is_rem_q <= 1'b0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         rd_q     <= '0;
         quo_q    <= '0;
         rem_q    <= '0;
         dvs_q    <= '0;
         res_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_rem_q <= is_rem_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         rd_q     <= rd_d;
         quo_q    <= quo_d;
         rem_q    <= rem_d;
         dvs_q    <= dvs_d;
         res_q    <= res_d;
      end
   end

   assign hold_req_o = ((state_q == IDLE) && start_i && !flush_i) || (state_q == CALC);
   assign busy_o     = (state_q != IDLE);
   assign valid_o    = (state_q == DONE) && !flush_i;
   assign regs_wen_o = valid_o;
   assign result_o   = res_q;
   assign rd_addr_o  = rd_q;
endmodule

// File: tb/tb_ex_div.sv
// Randomised scoreboard bench for ex_div against an arithmetic reference model.
module tb_ex_div;
   logic        clk = 1'b0;
   logic        rstn;
   logic        start_i;
   logic [1:0]  op_i;
   logic [31:0] dividend_i;
   logic [31:0] divisor_i;
   logic [4:0]  rd_addr_i;
   logic        flush_i;
   logic        hold_req_o;
   logic        busy_o;
   logic        valid_o;
   logic [31:0] result_o;
   logic [4:0]  rd_addr_o;
   logic        regs_wen_o;

   ex_div #(.XLEN(32), .CNT_W(5)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .start_i    (start_i),
      .op_i       (op_i),
      .dividend_i (dividend_i),
      .divisor_i  (divisor_i),
      .rd_addr_i  (rd_addr_i),
      .flush_i    (flush_i),
      .hold_req_o (hold_req_o),
      .busy_o     (busy_o),
      .valid_o    (valid_o),
      .result_o   (result_o),
      .rd_addr_o  (rd_addr_o),
      .regs_wen_o (regs_wen_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] res;
      logic [4:0]  rd;
      logic [31:0] cyc;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q, r;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'd0;
      end else if (!op[0]) begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end else begin
         q = a / b;
         r = a % b;
      end
      return op[1] ? r : q;
   endfunction

   // Monitor: every result the DUT presents must match the oldest expectation.
   always @(negedge clk) begin
      if (valid_o) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got result %h with empty scoreboard", result_o);
         end else begin
            mon_e = sb.pop_front();
            chk("result",   result_o,            mon_e.res);
            chk("rd_addr",  {27'd0, rd_addr_o},  {27'd0, mon_e.rd});
            chk("latency",  cyc,                 mon_e.cyc);
            chk("regs_wen", {31'd0, regs_wen_o}, 32'd1);
         end
      end
   end

   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int   hc;
      int   n;
      bit   sp;
      exp_t e;
      sp = is_special(op, a, b);
      @(negedge clk);
      start_i    = 1'b1;
      op_i       = op;
      dividend_i = a;
      divisor_i  = b;
      rd_addr_i  = 5'($urandom);
      e.res = ref_model(op, a, b);
      e.rd  = rd_addr_i;
      e.cyc = cyc + (sp ? 32'd1 : 32'd33);
      sb.push_back(e);
      #1 hc = int'(hold_req_o);
      @(negedge clk);
      start_i = 1'b0;
      n = 0;
      while (busy_o && n < 60) begin
         #1 hc += int'(hold_req_o);
         @(negedge clk);
         n++;
      end
      if (n >= 60) begin
         checks++;
         errors++;
         $display("FAIL op_timeout: busy_o still high after %0d cycles, required idle", n);
      end
      chk("hold_cycles", hc, sp ? 32'd1 : 32'd33);
   endtask

   initial begin
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      rstn = 1'b0; start_i = 1'b0; op_i = 2'd0; dividend_i = '0; divisor_i = '0;
      rd_addr_i = '0; flush_i = 1'b0;
      #12;
      chk("reset_ctrl", {28'd0, busy_o, hold_req_o, valid_o, regs_wen_o}, 32'd0);
      chk("reset_result", result_o, 32'd0);
      chk("reset_rd", {27'd0, rd_addr_o}, 32'd0);
      @(negedge clk);
      rstn = 1'b1;

      do_op(2'b01, 32'd100, 32'd7);
      do_op(2'b11, 32'd100, 32'd7);
      do_op(2'b00, 32'hFFFF_FFF9, 32'd2);
      do_op(2'b10, 32'hFFFF_FFF9, 32'd2);
      do_op(2'b00, 32'd7, 32'hFFFF_FFFE);
      do_op(2'b01, 32'd5, 32'd0);
      do_op(2'b11, 32'd5, 32'd0);
      do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
      do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);

      // Flush at the tenth CALC cycle: no result may ever appear.
      @(negedge clk);
      start_i = 1'b1; op_i = 2'b01; dividend_i = 32'd1000; divisor_i = 32'd3;
      @(negedge clk);
      start_i = 1'b0;
      repeat (9) @(negedge clk);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      #1;
      chk("flush_busy", {31'd0, busy_o}, 32'd0);
      chk("flush_hold", {31'd0, hold_req_o}, 32'd0);
      do_op(2'b01, 32'd9, 32'd3);

      // Flush coinciding with start wins: the divider must stay idle.
      @(negedge clk);
      start_i = 1'b1; flush_i = 1'b1; op_i = 2'b01; dividend_i = 32'd50; divisor_i = 32'd5;
      #1 chk("flush_start_hold", {31'd0, hold_req_o}, 32'd0);
      @(negedge clk);
      start_i = 1'b0; flush_i = 1'b0;
      #1 chk("flush_start_busy", {31'd0, busy_o}, 32'd0);

      // Asynchronous reset in the middle of CALC.
      @(negedge clk);
      start_i = 1'b1; op_i = 2'b01; dividend_i = 32'd100; divisor_i = 32'd3; rd_addr_i = 5'd17;
      @(negedge clk);
      start_i = 1'b0;
      repeat (5) @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      chk("arst_ctrl", {28'd0, busy_o, hold_req_o, valid_o, regs_wen_o}, 32'd0);
      chk("arst_result", result_o, 32'd0);
      chk("arst_rd", {27'd0, rd_addr_o}, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      do_op(2'b01, 32'd8, 32'd2);

      for (int i = 0; i < 40; i++) begin
         rop = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 5))
            0: begin ra = $urandom; rb = 32'd0; end
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: begin ra = 32'($urandom_range(0, 300)) - 32'd150; rb = 32'($urandom_range(1, 20)); end
            3: begin ra = $urandom; rb = 32'd0 - 32'($urandom_range(1, 9)); end
            default: begin ra = $urandom; rb = $urandom >> $urandom_range(0, 31); end
         endcase
         do_op(rop, ra, rb);
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
